// File: rtl/gb_lcd_tx_pkg.sv
// Shared constants, types and sync decode for the Game Boy LCD transmitter.
package gb_lcd_pkg;

    localparam int GB_H_ACTIVE     = 160;
    localparam int GB_V_ACTIVE     = 144;
    localparam int GB_H_TOTAL      = 228;
    localparam int GB_V_TOTAL      = 154;
    localparam int GB_HSYNC_W      = 8;
    localparam int GB_VSYNC_LINES  = 1;
    localparam int GB_CLK_DIV      = 2;
    localparam int GB_FRAME_PIXELS = GB_H_ACTIVE * GB_V_ACTIVE;

    typedef logic [1:0] shade_t;

    localparam shade_t SHADE_WHITE = 2'd0;
    localparam shade_t SHADE_LIGHT = 2'd1;
    localparam shade_t SHADE_DARK  = 2'd2;
    localparam shade_t SHADE_BLACK = 2'd3;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } lcd_sync_t;

    // Decode the qualifiers of slot (h,v); all compares unsigned.
    function automatic lcd_sync_t gb_sync_decode(
        input int unsigned h,
        input int unsigned v,
        input int unsigned ha,
        input int unsigned va,
        input int unsigned hs,
        input int unsigned vs
    );
        lcd_sync_t s;
        s.de    = (h < ha) && (v < va);
        s.hsync = (h >= ha) && (h < ha + hs);
        s.vsync = (v >= va) && (v < va + vs);
        return s;
    endfunction

endpackage

// File: rtl/gb_lcd_tx_if.sv
// Pixel source handshake: the source is master, the transmitter is slave.
interface gb_lcd_tx_if;
    import gb_lcd_pkg::*;

    shade_t pix_data;
    logic   pix_valid;
    logic   pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/gb_lcd_timing.sv
// Slot/line/frame counters with registered LCD timing outputs and the fetch strobe.
module gb_lcd_timing
    import gb_lcd_pkg::*;
#(
    parameter int H_ACTIVE    = GB_H_ACTIVE,
    parameter int H_TOTAL     = GB_H_TOTAL,
    parameter int V_ACTIVE    = GB_V_ACTIVE,
    parameter int V_TOTAL     = GB_V_TOTAL,
    parameter int HSYNC_W     = GB_HSYNC_W,
    parameter int VSYNC_LINES = GB_VSYNC_LINES,
    parameter int CLK_DIV     = GB_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_fetch,
    output logic o_slot_adv,
    output logic o_next_first,
    output logic o_pclk,
    output logic o_de,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_frame_start
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] PCLK_HI  = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_pclk;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_start;

    logic          w_run;
    logic          w_div_last;
    logic [DW-1:0] w_div_next;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    lcd_sync_t     w_sync_next;
    logic          w_next_first;

    // Position of the upcoming slot and its sync decode
    always_comb begin
        w_run      = i_en & ~i_rst;
        w_div_last = (r_div == DIV_LAST);
        w_div_next = w_div_last ? '0 : r_div + 1'b1;
        w_h_next   = (r_h == H_LAST) ? '0 : r_h + 1'b1;
        w_v_next   = r_v;
        if (r_h == H_LAST) begin
            w_v_next = (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end
        w_sync_next  = gb_sync_decode(32'(w_h_next), 32'(w_v_next),
                                      H_ACTIVE, V_ACTIVE, HSYNC_W, VSYNC_LINES);
        w_next_first = (w_h_next == '0) && (w_v_next == '0);
    end

    assign o_slot_adv    = w_run & w_div_last;
    assign o_fetch       = w_run & w_div_last & w_sync_next.de;
    assign o_next_first  = w_next_first;
    assign o_pclk        = r_pclk;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

    // Counters; idle presets the pre-slot so slot (0,0) follows the priming cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_div <= DIV_LAST;
            r_h   <= H_LAST;
            r_v   <= V_LAST;
        end else begin
            r_div <= w_div_next;
            if (w_div_last) begin
                r_h <= w_h_next;
                r_v <= w_v_next;
            end
        end
    end

    // Registered timing outputs; qualifiers only change as a new slot begins
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_pclk        <= 1'b0;
            r_de          <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pclk        <= (w_div_next >= PCLK_HI);
            r_frame_start <= w_div_last & w_next_first;
            if (w_div_last) begin
                r_de    <= w_sync_next.de;
                r_hsync <= w_sync_next.hsync;
                r_vsync <= w_sync_next.vsync;
            end
        end
    end

endmodule

// File: rtl/gb_lcd_tx.sv
// Game Boy LCD pixel transmitter: timing generator plus pixel fetch and underrun tracking.
module gb_lcd_tx
    import gb_lcd_pkg::*;
#(
    parameter int H_ACTIVE    = GB_H_ACTIVE,
    parameter int H_TOTAL     = GB_H_TOTAL,
    parameter int V_ACTIVE    = GB_V_ACTIVE,
    parameter int V_TOTAL     = GB_V_TOTAL,
    parameter int HSYNC_W     = GB_HSYNC_W,
    parameter int VSYNC_LINES = GB_VSYNC_LINES,
    parameter int CLK_DIV     = GB_CLK_DIV
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    gb_lcd_tx_if.slave  pix,
    output logic        gb_pclk,
    output logic        gb_de,
    output logic        gb_hsync,
    output logic        gb_vsync,
    output logic [1:0]  gb_pixel,
    output logic        frame_start,
    output logic        underrun
);

    logic   w_fetch;
    logic   w_slot_adv;
    logic   w_next_first;
    shade_t r_pixel;
    logic   r_underrun;

    gb_lcd_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .H_TOTAL     (H_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .V_TOTAL     (V_TOTAL),
        .HSYNC_W     (HSYNC_W),
        .VSYNC_LINES (VSYNC_LINES),
        .CLK_DIV     (CLK_DIV)
    ) u_timing (
        .i_clk         (pclk),
        .i_rst         (rst),
        .i_en          (en),
        .o_fetch       (w_fetch),
        .o_slot_adv    (w_slot_adv),
        .o_next_first  (w_next_first),
        .o_pclk        (gb_pclk),
        .o_de          (gb_de),
        .o_hsync       (gb_hsync),
        .o_vsync       (gb_vsync),
        .o_frame_start (frame_start)
    );

    assign pix.pix_ready = w_fetch;
    assign gb_pixel      = r_pixel;
    assign underrun      = r_underrun;

    // Pixel register loads on slot entry; blank or starved slots show white
    always_ff @(posedge pclk) begin
        if (rst || !en) begin
            r_pixel <= SHADE_WHITE;
        end else if (w_slot_adv) begin
            r_pixel <= (w_fetch && pix.pix_valid) ? pix.pix_data : SHADE_WHITE;
        end
    end

    // Sticky underrun; the frame's first fetch clears it unless it also starves
    always_ff @(posedge pclk) begin
        if (rst || !en) begin
            r_underrun <= 1'b0;
        end else if (w_fetch) begin
            if (!pix.pix_valid) begin
                r_underrun <= 1'b1;
            end else if (w_next_first) begin
                r_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/gb_lcd_tx.md
Name: gb_lcd_tx

Overview:
- Transmitter side of the Game Boy LCD pixel interface (gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel) that the frame-buffer writer consumes.
- Pulls 2-bit shade pixels from an upstream source over a valid/ready handshake.
- Emits them in raster order with LCD line/frame timing, all derived from one system clock.
- Used as a test-pattern/emulated-PPU source and as the PPU output stage.

Parameters:
H_ACTIVE, 160, visible pixel slots per line
H_TOTAL, 228, pixel slots per line including blanking (> H_ACTIVE+HSYNC_W)
V_ACTIVE, 144, visible lines per frame
V_TOTAL, 154, lines per frame (> V_ACTIVE+VSYNC_LINES-1)
HSYNC_W, 8, hsync width in pixel slots
VSYNC_LINES, 1, vsync width in lines
CLK_DIV, 2, system clocks per pixel slot; even, >= 2

Ports:
pclk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  LCD on; low holds block idle
pix_data  in  2  shade 0=white..3=black
pix_valid  in  1  pix_data valid
pix_ready  out  1  pixel fetch strobe; transfer = pix_valid & pix_ready
gb_pclk  out  1  pixel clock, free-running while en
gb_de  out  1  active-pixel qualifier
gb_hsync  out  1  line sync, active high
gb_vsync  out  1  frame sync, active high
gb_pixel  out  2  pixel shade
frame_start  out  1  one-cycle pulse at start of slot (0,0)
underrun  out  1  sticky: a visible pixel was fetched without pix_valid

Behaviour:
- Reset is synchronous, active-high and overrides everything.
  - All outputs reset to 0.
  - Internal state is preset to the "pre-slot": div_cnt=CLK_DIV-1, h=H_TOTAL-1, v=V_TOTAL-1.
- While en=0, same as reset: outputs 0, state held at pre-slot.
  - Deasserting en mid-frame takes effect the next cycle; no partial-line completion.
- Slot timing: div_cnt counts 0..CLK_DIV-1.
  - h/v advance when div_cnt==CLK_DIV-1.
  - h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0.
- gb_pclk = 1 iff div_cnt >= CLK_DIV/2, registered. Low for the first half of each slot, high for the second.
- gb_de, gb_hsync, gb_vsync and gb_pixel are registered and change only on cycles where div_cnt becomes 0. They are therefore stable across the gb_pclk rising edge (mid-slot).
- During slot (h,v):
  - gb_de = (h < H_ACTIVE) & (v < V_ACTIVE)
  - gb_hsync = (H_ACTIVE <= h < H_ACTIVE+HSYNC_W), on every line including blanking lines
  - gb_vsync = (V_ACTIVE <= v < V_ACTIVE+VSYNC_LINES), for whole lines
  - gb_pixel = the fetched pixel when gb_de=1, else 2'b00
- Fetch:
  - pix_ready is asserted only when en=1, div_cnt==CLK_DIV-1, and the next slot is visible.
  - Pixel accepted at cycle t appears on gb_pixel at t+1 for CLK_DIV cycles (latency 1).
  - Exactly H_ACTIVE*V_ACTIVE fetches per frame.
- Underrun: on a fetch cycle with pix_valid=0:
  - the slot outputs 2'b00 with gb_de still 1;
  - underrun is set.
  - underrun is cleared on the fetch cycle for slot (0,0); a simultaneous failed fetch sets it (set wins).
- frame_start: pulses on the cycle slot (0,0) begins, i.e. the cycle gb_de first rises in a frame.
- First cycle after rst=0 with en=1 is the priming fetch cycle (pix_ready=1); slot (0,0) begins the following cycle.
- Counter widths are $clog2 of the respective totals; all compares are unsigned.

Decomposition:
- Package gb_lcd_pkg:
  - GB_H_ACTIVE=160, GB_V_ACTIVE=144, GB_H_TOTAL=228, GB_V_TOTAL=154
  - 2-bit shade constants SHADE_WHITE/LIGHT/DARK/BLACK
  - GB_FRAME_PIXELS=23040
- Sub-module gb_lcd_timing: div_cnt/h/v counters plus registered de/hsync/vsync/gb_pclk decode and a fetch strobe.
- gb_lcd_tx wraps gb_lcd_timing with the pixel register, handshake and underrun logic.

Test Plan:
- Defaults; rst then en=1, pix_valid=1, incrementing pix_data:
  - pix_ready at cycle 0; gb_de high cycles 1..320 of line 0.
  - 160 gb_pclk rising edges with gb_de=1 per line.
  - Data sampled at those edges = fetched sequence.
  - 23040 pixels per frame.
- Same run, check syncs and frame timing:
  - gb_hsync rises at cycle 321, width 16 cycles.
  - gb_vsync rises at cycle 65665, width 456 cycles.
  - frame_start period 70224 cycles.
- Deassert pix_valid only on fetch of pixel (5,0):
  - that slot gb_pixel=00 with gb_de=1;
  - underrun=1 through frame end;
  - clears at next frame's (0,0) fetch with valid.
- en=0 during line 10, hold 50 cycles, en=1:
  - outputs 0 next cycle, pix_ready=0 while low;
  - on re-enable, priming fetch then frame_start next cycle at (0,0).
- rst=1 for one cycle mid-line 100 with en=1: identical restart to cold reset, underrun=0.
- CLK_DIV=4, H_TOTAL=20, V_TOTAL=6, H_ACTIVE=4, V_ACTIVE=3:
  - gb_pclk 2 low / 2 high;
  - outputs change only at div_cnt 0;
  - 12 fetches/frame.
